// File: rtl/adc_spi_pkg.sv
// Shared types and frame geometry for the serial-ADC front end.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_IDLE
    } adc_state_e;

    localparam int FRAME_BITS   = 17;
    localparam int CMD_BITS     = 6;
    localparam int NULL_BIT_IDX = 6;
    localparam int DATA_BITS    = 10;
    localparam int OVS_FRAMES   = 4;

    // Command = start, single-ended, chan[3:0]; null bit and data slots shift out as 0.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] chan);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1 -: CMD_BITS] = {2'b11, chan};
        return f;
    endfunction

endpackage

// File: rtl/adc_spi_frontend_sclk_gen.sv
// SPI clock generator: SCLK_HALF cycles low then high while enabled, with
// single-cycle strobes in the cycle before each rising/falling sclk edge.
module adc_sclk_gen #(
    parameter int SCLK_HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    assign tc = en_i && (cnt_q == CW'(SCLK_HALF - 1));

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = tc && !sclk_q;
    assign fall_o = tc && sclk_q;

endmodule

// File: rtl/adc_spi_frontend.sv
// Serial SAR-ADC responder: one SPI frame per adc_go, result returned with adc_valid.
// Define ADC_OVERSAMPLE_EN to average OVS_FRAMES back-to-back frames per request.
module adc_spi_frontend
    import adc_spi_pkg::*;
#(
    parameter int SCLK_HALF   = 2,
    parameter int CS_IDLE_CYC = 4
) (
    input  logic                 clk3p2M,
    input  logic                 reset,
    input  logic                 adc_go,
    input  logic [3:0]           adc_chan,
    output logic [DATA_BITS-1:0] adc_in,
    output logic                 adc_valid,
    output logic                 adc_busy,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic                 adc_mosi,
    input  logic                 adc_miso
);

    // Two synchroniser flops push the sample point two cycles past the rising
    // edge, which only stays inside the high phase for SCLK_HALF >= 2.
    localparam bit ADC_MISO_SYNC = (SCLK_HALF > 1);
    localparam int CNT_W         = 16;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] IDLE_M1 = CNT_W'(CS_IDLE_CYC - 1);

    adc_state_e state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [4:0]            bit_q, bit_d;
    logic [4:0]            samp_q, samp_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic [DATA_BITS-1:0]  in_q, in_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  cs_n_q, cs_n_d;

`ifdef ADC_OVERSAMPLE_EN
    localparam int FRM_W = $clog2(OVS_FRAMES);
    localparam int SUM_W = DATA_BITS + FRM_W;
    logic [3:0]       chan_q, chan_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic [SUM_W-1:0] sum_q, sum_d, acc;
`endif

    logic sclk_rise, sclk_fall;
    logic miso_s, samp_stb;

    adc_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
        .clk_i  (clk3p2M),
        .rst_i  (reset),
        .en_i   (state_q == SHIFT),
        .sclk_o (adc_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    generate
        if (ADC_MISO_SYNC) begin : g_sync
            logic [1:0] sync_q;
            logic [1:0] rise_q;
            always_ff @(posedge clk3p2M or posedge reset) begin
                if (reset) begin
                    sync_q <= '0;
                    rise_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], adc_miso};
                    rise_q <= {rise_q[0], sclk_rise};
                end
            end
            assign miso_s   = sync_q[1];
            assign samp_stb = rise_q[1];
        end else begin : g_nosync
            assign miso_s   = adc_miso;
            assign samp_stb = sclk_rise;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        data_d  = data_q;
        in_d    = in_q;
        valid_d = 1'b0;
`ifdef ADC_OVERSAMPLE_EN
        chan_d  = chan_q;
        frm_d   = frm_q;
        sum_d   = sum_q;
        acc     = sum_q + SUM_W'(data_q);
`endif

        // Command and null-bit samples are counted but never enter data_q.
        if (samp_stb) begin
            samp_d = samp_q + 5'd1;
            if (samp_q > 5'(NULL_BIT_IDX))
                data_d = {data_q[DATA_BITS-2:0], miso_s};
        end

        case (state_q)
            IDLE: begin
                if (adc_go) begin
                    frame_d = build_frame(adc_chan);
                    cnt_d   = '0;
                    bit_d   = '0;
                    samp_d  = '0;
                    state_d = CS_SETUP;
`ifdef ADC_OVERSAMPLE_EN
                    chan_d  = adc_chan;
                    frm_d   = '0;
                    sum_d   = '0;
`endif
                end
            end
            CS_SETUP: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_q == 5'(FRAME_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = CS_HOLD;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = CS_IDLE;
`ifdef ADC_OVERSAMPLE_EN
                    // frm_q wraps to 0 after the last frame, which CS_IDLE reads as done.
                    frm_d = frm_q + 1'b1;
                    sum_d = acc;
                    if (frm_q == FRM_W'(OVS_FRAMES - 1)) begin
                        in_d    = acc[SUM_W-1 -: DATA_BITS];
                        valid_d = 1'b1;
                    end
`else
                    in_d    = data_q;
                    valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CS_IDLE: begin
                if (cnt_q == IDLE_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef ADC_OVERSAMPLE_EN
                    if (frm_q != '0) begin
                        frame_d = build_frame(chan_q);
                        bit_d   = '0;
                        samp_d  = '0;
                        state_d = CS_SETUP;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk3p2M or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            data_q  <= '0;
            in_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
`ifdef ADC_OVERSAMPLE_EN
            chan_q  <= '0;
            frm_q   <= '0;
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            data_q  <= data_d;
            in_q    <= in_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
`ifdef ADC_OVERSAMPLE_EN
            chan_q  <= chan_d;
            frm_q   <= frm_d;
            sum_q   <= sum_d;
`endif
        end
    end

    assign adc_in    = in_q;
    assign adc_valid = valid_q;
    assign adc_busy  = busy_q;
    assign adc_cs_n  = cs_n_q;
    assign adc_mosi  = frame_q[FRAME_BITS-1];

endmodule

// File: tb/tb_adc_spi_frontend.sv
// Directed bench for adc_spi_frontend with a behavioural mode-0 ADC model.
module tb_adc_spi_frontend;

`ifdef ADC_OVERSAMPLE_EN
    localparam int LAT = 301;
    localparam int CSL = 288;
`else
    localparam int LAT = 73;
    localparam int CSL = 72;
`endif
    localparam int BUSYC = LAT + 3;
    localparam int WIN   = LAT + 40;

    logic       clk3p2M = 1'b0;
    logic       reset = 1'b0;
    logic       adc_go = 1'b0;
    logic [3:0] adc_chan = '0;
    logic [9:0] adc_in;
    logic       adc_valid, adc_busy, adc_cs_n, adc_sclk, adc_mosi;
    logic       adc_miso = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    adc_spi_frontend #(.SCLK_HALF(2), .CS_IDLE_CYC(4)) dut (
        .clk3p2M   (clk3p2M),
        .reset     (reset),
        .adc_go    (adc_go),
        .adc_chan  (adc_chan),
        .adc_in    (adc_in),
        .adc_valid (adc_valid),
        .adc_busy  (adc_busy),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .adc_mosi  (adc_mosi),
        .adc_miso  (adc_miso)
    );

    always #156 clk3p2M = ~clk3p2M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ADC model: data changes after each falling sclk, mosi captured on rising sclk.
    logic [9:0]  vals [4];
    logic        null_drv = 1'b0;
    int          fidx = 0;
    int          nfall = 0;
    logic [16:0] rx = '0;
    logic        cs_p = 1'b1;
    logic        sclk_p = 1'b0;

    function automatic logic mbit(input int p, input logic [9:0] v, input logic nb);
        if (p == 6) return nb;
        if (p >= 7 && p <= 16) return v[16-p];
        return 1'b0;
    endfunction

    always @(adc_cs_n or adc_sclk or reset) begin
        if (reset) fidx = 0;
        else if (cs_p === 1'b0 && adc_cs_n === 1'b1) fidx = fidx + 1;
        if (cs_p === 1'b1 && adc_cs_n === 1'b0) begin
            nfall = 0;
            rx = '0;
            adc_miso = 1'b0;
        end
        if (sclk_p === 1'b0 && adc_sclk === 1'b1) rx = {rx[15:0], adc_mosi};
        if (sclk_p === 1'b1 && adc_sclk === 1'b0 && adc_cs_n === 1'b0) begin
            nfall++;
            adc_miso = mbit(nfall, vals[fidx & 3], null_drv);
        end
        cs_p = adc_cs_n;
        sclk_p = adc_sclk;
    end

    task automatic run_frame(input logic [3:0] ch, input logic [9:0] d, input bit setv,
                             input bit pulses, input logic [9:0] exp_in, input string tag);
        int n_valid, vcyc, cs_low, busy_n;
        bit held_bad;
        logic [9:0] prev;
        if (setv) for (int i = 0; i < 4; i++) vals[i] = d;
        @(negedge clk3p2M);
        adc_chan = ch;
        adc_go = 1'b1;
        prev = adc_in;
        n_valid = 0; vcyc = 0; cs_low = 0; busy_n = 0; held_bad = 1'b0;
        for (int n = 1; n <= WIN; n++) begin
            @(negedge clk3p2M);
            adc_go = pulses && (n == 10 || n == 40 || n == LAT);
            if (adc_cs_n == 1'b0) cs_low++;
            if (adc_busy) busy_n++;
            if (adc_valid) begin
                n_valid++;
                if (vcyc == 0) vcyc = n;
                prev = adc_in;
            end else if (adc_in !== prev) begin
                held_bad = 1'b1;
            end
        end
        adc_go = 1'b0;
        chk({tag, ".lat"}, vcyc, LAT);
        chk({tag, ".nvalid"}, n_valid, 1);
        chk({tag, ".cslow"}, cs_low, CSL);
        chk({tag, ".busy"}, busy_n, BUSYC);
        chk({tag, ".data"}, adc_in, exp_in);
        chk({tag, ".hold"}, held_bad, 0);
        chk({tag, ".mosi"}, rx, {2'b11, ch, 1'b0, 10'b0});
    endtask

    task automatic reset_abort();
        int nv;
        for (int i = 0; i < 4; i++) vals[i] = 10'h3C3;
        @(negedge clk3p2M);
        adc_chan = 4'd7;
        adc_go = 1'b1;
        @(negedge clk3p2M);
        adc_go = 1'b0;
        repeat (29) @(negedge clk3p2M);
        reset = 1'b1;
        #1;
        chk("rst.csn", adc_cs_n, 1'b1);
        chk("rst.sclk", adc_sclk, 1'b0);
        chk("rst.din", adc_in, 10'h000);
        chk("rst.busy", adc_busy, 1'b0);
        nv = 0;
        repeat (3) begin
            @(negedge clk3p2M);
            if (adc_valid) nv++;
        end
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk3p2M);
            if (adc_valid || !adc_cs_n) nv++;
        end
        chk("rst.quiet", nv, 0);
        run_frame(4'd7, 10'h3C3, 1'b1, 1'b0, 10'h3C3, "rst.after");
    endtask

    initial begin
        #(312 * 30000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk3p2M);
        chk("init.csn", adc_cs_n, 1'b1);
        chk("init.sclk", adc_sclk, 1'b0);
        chk("init.mosi", adc_mosi, 1'b0);
        chk("init.valid", adc_valid, 1'b0);
        chk("init.busy", adc_busy, 1'b0);
        chk("init.din", adc_in, 10'h000);
        reset = 1'b0;
        repeat (2) @(negedge clk3p2M);

        run_frame(4'd5, 10'h2A5, 1'b1, 1'b0, 10'h2A5, "ch5");
        for (int c = 0; c < 16; c++)
            run_frame(4'(c), {4'(c), 6'h3F}, 1'b1, 1'b0, {4'(c), 6'h3F}, $sformatf("sweep%0d", c));
        run_frame(4'd9, 10'h155, 1'b1, 1'b1, 10'h155, "ignore");
        reset_abort();

        null_drv = 1'b1;
        run_frame(4'd2, 10'h000, 1'b1, 1'b0, 10'h000, "null");
        null_drv = 1'b0;

`ifdef ADC_OVERSAMPLE_EN
        @(negedge clk3p2M);
        reset = 1'b1;
        @(negedge clk3p2M);
        reset = 1'b0;
        vals[0] = 10'd100;
        vals[1] = 10'd101;
        vals[2] = 10'd102;
        vals[3] = 10'd104;
        run_frame(4'd3, 10'd0, 1'b0, 1'b0, 10'd101, "ovs");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
